// File: rtl/seq_mult_n.sv
// seq_mult_n: iterative shift-add multiplier, one partial product per clock.
// Operands are latched on an accepted start; the result appears after
// WIDTH shift-add steps plus one finishing cycle, with a one-cycle done pulse.
// Macro SEQ_MULT_SIGNED_EN enables two's-complement operation via sign_mode.
// Without it, sign_mode is ignored and the block multiplies unsigned only.
module seq_mult_n #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               ready,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic               accept;
  logic               last_step;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // A new operation is accepted only when not busy calculating.
  assign accept    = (state_reg != CALC) && start;
  // The counter reaching WIDTH means all shift-add steps are complete.
  assign last_step = (cnt_reg == CNT_W'(WIDTH));

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_reg;

  // Magnitudes of the operands; the most negative value maps onto its
  // unsigned magnitude naturally because the negation wraps in WIDTH bits.
  always_comb begin
    a_mag = (sign_mode && A[WIDTH-1]) ? -A : A;
    b_mag = (sign_mode && B[WIDTH-1]) ? -B : B;
  end

  // Result-sign flag, captured with the operands on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_reg <= 1'b0;
    end else if (accept) begin
      neg_reg <= (A[WIDTH-1] ^ B[WIDTH-1]) & sign_mode;
    end
  end
`else
  logic unused_sign_mode;
  assign unused_sign_mode = sign_mode;

  // Unsigned-only build: operands pass straight through.
  always_comb begin
    a_mag = A;
    b_mag = B;
  end
`endif

  // One shift-add partial sum; the extra top bit keeps the carry.
  always_comb begin
    sum = {1'b0, product_reg[2*WIDTH-1:WIDTH]} +
          (product_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start is ignored while calculating.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = FIN;
      FIN:     state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: idle/finished states accept work, FIN flags the result.
  always_comb begin
    ready = 1'b1;
    done  = 1'b0;
    case (state_reg)
      CALC:    ready = 1'b0;
      FIN:     done  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on accept, shift-add while calculating, and
  // apply the sign correction on the step that leaves CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      product_reg <= '0;
    end else if (accept) begin
      cnt_reg     <= '0;
      mcand_reg   <= a_mag;
      product_reg <= {{WIDTH{1'b0}}, b_mag};
    end else if (state_reg == CALC && !last_step) begin
      cnt_reg     <= cnt_reg + 1'b1;
      product_reg <= {sum, product_reg[WIDTH-1:1]};
    end
`ifdef SEQ_MULT_SIGNED_EN
    else if (state_reg == CALC && last_step && neg_reg) begin
      product_reg <= -product_reg;
    end
`endif
  end

  assign Product = product_reg;

endmodule

// File: tb/tb_seq_mult_n.sv
// tb_seq_mult_n: randomized and directed checks of seq_mult_n (WIDTH=8)
// against a plain-arithmetic reference product.
module tb_seq_mult_n;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           sign_mode;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2*W-1:0] Product;
  logic           ready;
  logic           done;

  int checks = 0;
  int errors = 0;

  seq_mult_n #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sign_mode (sign_mode),
    .A         (A),
    .B         (B),
    .Product   (Product),
    .ready     (ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference product from integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    longint pa;
    longint pb;
    logic   eff;
    eff = sm;
`ifndef SEQ_MULT_SIGNED_EN
    eff = 1'b0;
`endif
    if (eff) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return (2*W)'(pa * pb);
  endfunction

  // Present operands with start high; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    A = a;
    B = b;
    sign_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Wait for done (bounded); reports cycles since the accept edge and
  // whether ready was seen high during the calculation.
  task automatic wait_done(output int cyc, output logic rdy_hi);
    cyc = 0;
    rdy_hi = 1'b0;
    while (!done && cyc < 40) begin
      if (ready) rdy_hi = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Full operation: accept, scramble inputs afterwards, check latency/result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic hold, input string tag);
    logic [2*W-1:0] exp;
    int   cyc;
    logic rdy_hi;
    exp = model(a, b, sm);
    issue(a, b, sm);
    if (!hold) start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    sign_mode = 1'($urandom);
    wait_done(cyc, rdy_hi);
    $display("op %s A=0x%02h B=0x%02h sm=%0d Product=0x%04h cycles=%0d", tag, a, b, sm, Product, cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    chk({tag, "_product"}, 64'(Product), 64'(exp));
    chk({tag, "_ready_calc"}, 64'(rdy_hi), 64'd0);
    chk({tag, "_ready_fin"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int   cyc;
    logic rdy_hi;
    logic seen_done;
    logic [2*W-1:0] last;

    rst_n = 1'b0;
    start = 1'b0;
    sign_mode = 1'b0;
    A = '0;
    B = '0;
    #2;
    chk("reset_product", 64'(Product), 64'd0);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases.
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "ff_ff_u");
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_pulse_one_cycle", 64'(done), 64'd0);
    last = model(8'hFF, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    chk("product_hold", 64'(Product), 64'(last));

    run_op(8'h80, 8'h80, 1'b1, 1'b0, "m128_sq");
    run_op(8'h80, 8'h01, 1'b1, 1'b0, "m128_x1");
    run_op(8'hFF, 8'h02, 1'b1, 1'b0, "ff_x2_s");
    run_op(8'h7F, 8'h81, 1'b1, 1'b0, "max_min");

    // Start held through the whole calculation: exactly one result.
    run_op(8'hFF, 8'h02, 1'b0, 1'b1, "held_start");
    start = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back: re-issue in the FIN cycle.
    run_op(8'd3, 8'd5, 1'b0, 1'b0, "b2b_first");
    run_op(8'd7, 8'd9, 1'b0, 1'b0, "b2b_second");
    start = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-calculation aborts with no done pulse.
    issue(8'hAB, 8'hCD, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_product", 64'(Product), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    run_op(8'd2, 8'd3, 1'b0, 1'b0, "after_reset");

    // Randomized operations, alternating single and back-to-back issue.
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, 1'b0, "rand");
      if ($urandom_range(0, 1) == 0) begin
        start = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    wait_done(cyc, rdy_hi);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
